// File: rtl/stream_pf_pkg.sv
// Shared types and constants for the stream prefetcher.
// Contents: FSM state enum, line/packet widths, packet field offsets
// and the packed packet layout written into stream_buffer.
package stream_pf_pkg;

   localparam int unsigned LINE_ADDR_WIDTH = 28;
   localparam int unsigned LINE_WIDTH      = 128;
   localparam int unsigned PACKET_WIDTH    = 1 + LINE_ADDR_WIDTH + LINE_WIDTH;

   // Packet field offsets: {valid, line_addr, data}
   localparam int unsigned DATA_LSB  = 0;
   localparam int unsigned ADDR_LSB  = LINE_WIDTH;
   localparam int unsigned VALID_BIT = LINE_WIDTH + LINE_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      REQ,
      WRITE
   } pf_state_e;

   typedef struct packed {
      logic                       valid;
      logic [LINE_ADDR_WIDTH-1:0] line_addr;
      logic [LINE_WIDTH-1:0]      data;
   } pf_packet_t;

endpackage

// File: rtl/stream_prefetcher.sv
// Fill engine upstream of stream_buffer. A miss flushes the buffer, then
// lines miss+1 .. miss+MAX_PREFETCH are read from memory one at a time and
// written into the buffer as {valid, line_addr, data} packets.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   start_i, start_addr_i         miss pulse and missing line address
//   stop_i                        abandon the current stream
//   buf_full_i                    stream_buffer full
//   buf_write_o, buf_flush_o      stream_buffer write / flush strobes
//   buf_packet_o                  packet presented to stream_buffer
//   mem_read_o, mem_addr_o        read request, held until mem_ready_i
//   mem_ready_i, mem_rdata_i      read completion and data
//   busy_o                        engine not idle
//   pf_lines_o                    lines written since reset (only with
//                                 STREAM_PF_STATS_EN defined)
// buf_write_o is a combinational decode of state and buf_full_i/start_i/
// stop_i so the write is dropped in the very cycle the buffer reports full.
module stream_prefetcher
   import stream_pf_pkg::*;
#(
   parameter int unsigned MAX_PREFETCH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic [LINE_ADDR_WIDTH-1:0] start_addr_i,
   input  logic                       stop_i,
   input  logic                       buf_full_i,
   output logic                       buf_write_o,
   output logic                       buf_flush_o,
   output logic [PACKET_WIDTH-1:0]    buf_packet_o,
   output logic                       mem_read_o,
   output logic [LINE_ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                       mem_ready_i,
   input  logic [LINE_WIDTH-1:0]      mem_rdata_i,
   output logic                       busy_o
`ifdef STREAM_PF_STATS_EN
  ,output logic [15:0]                pf_lines_o
`endif
);

   localparam int unsigned CNT_WIDTH = 8;
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PREFETCH);

   pf_state_e                  state_q, state_d;
   logic [LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]       count_q, count_d;
   logic                       pend_q, pend_d;
   logic [LINE_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic                       abort_q, abort_d;
   logic                       cap_en;
   logic                       write_c;

   pf_packet_t                 packet_q;
   logic                       flush_q;
   logic                       read_q;
   logic [LINE_ADDR_WIDTH-1:0] mem_addr_q;
   logic                       busy_q;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, stream bookkeeping and write strobe
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      abort_d     = abort_q;
      cap_en      = 1'b0;
      write_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d  = start_addr_i + LINE_ADDR_WIDTH'(1);
               count_d = '0;
               state_d = FLUSH;
            end
         end

         FLUSH: begin
            if (start_i) begin
               addr_d  = start_addr_i + LINE_ADDR_WIDTH'(1);
               count_d = '0;
               state_d = FLUSH;
            end else if (stop_i) begin
               state_d = IDLE;
            end else begin
               state_d = REQ;
            end
         end

         REQ: begin
            // Requests cannot be withdrawn: remember start/stop, act on completion.
            // The most recent of start/stop wins; start wins a same-cycle tie.
            if (start_i) begin
               pend_d      = 1'b1;
               pend_addr_d = start_addr_i;
               abort_d     = 1'b0;
            end else if (stop_i) begin
               pend_d  = 1'b0;
               abort_d = 1'b1;
            end
            if (mem_ready_i) begin
               if (pend_d) begin
                  addr_d  = pend_addr_d + LINE_ADDR_WIDTH'(1);
                  count_d = '0;
                  pend_d  = 1'b0;
                  state_d = FLUSH;
               end else if (abort_d) begin
                  abort_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  cap_en  = 1'b1;
                  addr_d  = addr_q + LINE_ADDR_WIDTH'(1);
                  count_d = count_q + CNT_WIDTH'(1);
                  state_d = WRITE;
               end
            end
         end

         WRITE: begin
            if (start_i) begin
               addr_d  = start_addr_i + LINE_ADDR_WIDTH'(1);
               count_d = '0;
               state_d = FLUSH;
            end else if (stop_i) begin
               state_d = IDLE;
            end else if (!buf_full_i) begin
               write_c = 1'b1;
               state_d = (count_q == MAX_CNT) ? IDLE : REQ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stream address, line count and pending start/stop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q      <= '0;
         count_q     <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         abort_q     <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         count_q     <= count_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         abort_q     <= abort_d;
      end
   end

   // Registered outputs, decoded from the next state so they align with state_q
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         packet_q   <= '0;
         flush_q    <= 1'b0;
         read_q     <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         flush_q    <= (state_d == FLUSH);
         read_q     <= (state_d == REQ);
         mem_addr_q <= (state_d == REQ) ? addr_d : '0;
         busy_q     <= (state_d != IDLE);
         if (cap_en) begin
            packet_q <= '{valid: 1'b1, line_addr: addr_q, data: mem_rdata_i};
         end
      end
   end

   assign buf_write_o  = write_c;
   assign buf_flush_o  = flush_q;
   assign buf_packet_o = packet_q;
   assign mem_read_o   = read_q;
   assign mem_addr_o   = mem_addr_q;
   assign busy_o       = busy_q;

`ifdef STREAM_PF_STATS_EN
   logic [15:0] lines_q;

   // Saturating count of lines delivered to the buffer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lines_q <= '0;
      end else if (write_c && (lines_q != 16'hFFFF)) begin
         lines_q <= lines_q + 16'd1;
      end
   end

   assign pf_lines_o = lines_q;
`endif

endmodule

// File: tb/tb_stream_prefetcher.sv
// Scoreboard bench for stream_prefetcher: the driver pushes the expected
// read addresses and packets of each stream, a memory responder and a
// buffer monitor pop and compare them as the DUT produces them.
module tb_stream_prefetcher;
   import stream_pf_pkg::*;

   localparam int unsigned MAX = 4;

   logic                       clk_i = 1'b0;
   logic                       rst_ni;
   logic                       start_i;
   logic [LINE_ADDR_WIDTH-1:0] start_addr_i;
   logic                       stop_i;
   logic                       buf_full_i;
   logic                       buf_write_o;
   logic                       buf_flush_o;
   logic [PACKET_WIDTH-1:0]    buf_packet_o;
   logic                       mem_read_o;
   logic [LINE_ADDR_WIDTH-1:0] mem_addr_o;
   logic                       mem_ready_i;
   logic [LINE_WIDTH-1:0]      mem_rdata_i;
   logic                       busy_o;
`ifdef STREAM_PF_STATS_EN
   logic [15:0]                pf_lines_o;
`endif

   stream_prefetcher #(.MAX_PREFETCH(MAX)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .start_addr_i (start_addr_i),
      .stop_i       (stop_i),
      .buf_full_i   (buf_full_i),
      .buf_write_o  (buf_write_o),
      .buf_flush_o  (buf_flush_o),
      .buf_packet_o (buf_packet_o),
      .mem_read_o   (mem_read_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ready_i  (mem_ready_i),
      .mem_rdata_i  (mem_rdata_i),
      .busy_o       (busy_o)
`ifdef STREAM_PF_STATS_EN
     ,.pf_lines_o   (pf_lines_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat_fixed = 3;
   bit strict_lat = 1'b0;
   int ready_cyc = 0;
   int exp_flush = 0;
   int seen_flush = 0;
   int n_writes = 0;
   bit in_prog = 1'b0;
   bit pend_start = 1'b0;
   int lat_left = 0;
   logic [LINE_ADDR_WIDTH-1:0] cur_addr = '0;
   logic [LINE_ADDR_WIDTH-1:0] exp_rd[$];
   logic [PACKET_WIDTH-1:0]    exp_wr[$];

   function automatic logic [LINE_WIDTH-1:0] data_of(input logic [LINE_ADDR_WIDTH-1:0] a);
      logic [31:0] w;
      w = {4'h0, a};
      return {w * 32'h9E37_79B1, w ^ 32'hDEAD_BEEF, ~w, {a[3:0], a}};
   endfunction

   task automatic check(input string name, input logic [PACKET_WIDTH-1:0] got,
                        input logic [PACKET_WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One driven cycle; entered and left at posedge+2.
   task automatic step(input bit st, input logic [LINE_ADDR_WIDTH-1:0] a,
                       input bit sp, input bit full);
      start_i      = st;
      start_addr_i = a;
      stop_i       = sp;
      buf_full_i   = full;
      if (st) begin
         if (in_prog) pend_start = 1'b1;
         else         exp_flush++;
         exp_rd.delete();
         exp_wr.delete();
         for (int i = 1; i <= int'(MAX); i++) begin
            logic [LINE_ADDR_WIDTH-1:0] x;
            x = a + LINE_ADDR_WIDTH'(i);
            exp_rd.push_back(x);
            exp_wr.push_back({1'b1, x, data_of(x)});
         end
      end else if (sp) begin
         pend_start = 1'b0;
         exp_rd.delete();
         exp_wr.delete();
      end
      @(posedge clk_i); #2;
      start_i = 1'b0;
      stop_i  = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      start_i = 1'b0; stop_i = 1'b0; buf_full_i = 1'b0;
      while ((busy_o || in_prog) && n < lim) begin
         @(posedge clk_i); #2;
         n++;
      end
      check("idle_timeout", 1'(n >= lim), 1'b0);
      check("idle_busy", busy_o, 1'b0);
      check("idle_wr_left", exp_wr.size(), 0);
      check("idle_rd_left", exp_rd.size(), 0);
   endtask

   // Memory responder: checks each request, holds it for a latency, returns data
   initial begin
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(posedge clk_i); #1;
         cyc++;
         if (!rst_ni) begin
            in_prog = 1'b0;
            mem_ready_i = 1'b0;
            continue;
         end
         if (mem_ready_i) begin
            mem_ready_i = 1'b0;
            in_prog = 1'b0;
            if (pend_start) begin
               exp_flush++;
               pend_start = 1'b0;
            end
            check("rd_after_ready", mem_read_o, 1'b0);
         end
         if (!in_prog && mem_read_o) begin
            if (exp_rd.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_unexpected: got read %0h required none", mem_addr_o);
            end else begin
               check("rd_addr", mem_addr_o, exp_rd.pop_front());
            end
            cur_addr = mem_addr_o;
            in_prog  = 1'b1;
            lat_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
         end else if (in_prog) begin
            check("rd_hold", mem_read_o, 1'b1);
            check("rd_addr_hold", mem_addr_o, cur_addr);
         end
         mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
         if (in_prog) begin
            if (lat_left == 0) begin
               mem_ready_i = 1'b1;
               mem_rdata_i = data_of(cur_addr);
               ready_cyc   = cyc;
            end else begin
               lat_left--;
            end
         end
      end
   end

   // Buffer-side monitor
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) continue;
         check("wr_flush_excl", buf_write_o & buf_flush_o, 1'b0);
         if (buf_flush_o) seen_flush++;
         if (buf_write_o) begin
            check("wr_while_full", buf_full_i, 1'b0);
            n_writes++;
            if (exp_wr.size() == 0) begin
               total++; bad++;
               $display("FAIL wr_unexpected: got packet %0h required none", buf_packet_o);
            end else begin
               check("wr_packet", buf_packet_o, exp_wr.pop_front());
            end
            if (strict_lat) check("wr_latency", cyc, ready_cyc + 1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish required finish by 1ms");
      $fatal(1);
   end

   // Stimulus
   initial begin
      int n;
      rst_ni = 1'b0;
      start_i = 1'b0; start_addr_i = '0; stop_i = 1'b0; buf_full_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_busy", busy_o, 1'b0);
      check("rst_read", mem_read_o, 1'b0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_flush", buf_flush_o, 1'b0);
      check("rst_write", buf_write_o, 1'b0);
      check("rst_packet", buf_packet_o, 0);
      rst_ni = 1'b1;
      @(posedge clk_i); #2;

      // Basic stream with fixed 3-cycle memory latency
      strict_lat = 1'b1;
      step(1'b1, 28'h0000100, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t1_flush_c1", buf_flush_o, 1'b1);
      check("t1_read_c1", mem_read_o, 1'b0);
      @(posedge clk_i); #2;
      @(negedge clk_i);
      check("t1_read_c2", mem_read_o, 1'b1);
      check("t1_addr_c2", mem_addr_o, 28'h0000101);
      check("t1_flush_c2", buf_flush_o, 1'b0);
      wait_idle(200);
      strict_lat = 1'b0;

      // Buffer full for 10 cycles while a packet waits
      step(1'b1, 28'h0000300, 1'b0, 1'b0);
      n = 0;
      while (!mem_ready_i && n < 50) begin step(1'b0, '0, 1'b0, 1'b0); n++; end
      check("t2_ready_seen", mem_ready_i, 1'b1);
      buf_full_i = 1'b1;
      @(posedge clk_i); #2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("t2_no_write_full", buf_write_o, 1'b0);
         check("t2_packet_hold", buf_packet_o, exp_wr.size() > 0 ? exp_wr[0] : '0);
         if (i < 9) begin @(posedge clk_i); #2; end
      end
      @(posedge clk_i); #2;
      buf_full_i = 1'b0;
      wait_idle(200);

      // New miss while a read of 0x102 is outstanding
      step(1'b1, 28'h0000100, 1'b0, 1'b0);
      n = 0;
      while (!(mem_read_o && mem_addr_o == 28'h0000102) && n < 50) begin
         step(1'b0, '0, 1'b0, 1'b0); n++;
      end
      check("t3_req_102_seen", mem_addr_o, 28'h0000102);
      step(1'b1, 28'h0000200, 1'b0, 1'b0);
      wait_idle(200);

      // Address wrap
      step(1'b1, 28'hFFFFFFE, 1'b0, 1'b0);
      wait_idle(200);

      // Asynchronous reset during a read
      step(1'b1, 28'h0000400, 1'b0, 1'b0);
      n = 0;
      while (!mem_read_o && n < 20) begin step(1'b0, '0, 1'b0, 1'b0); n++; end
      @(negedge clk_i); #2;
      rst_ni = 1'b0;
      #1;
      check("t5_read", mem_read_o, 1'b0);
      check("t5_addr", mem_addr_o, 0);
      check("t5_busy", busy_o, 1'b0);
      check("t5_flush", buf_flush_o, 1'b0);
      check("t5_write", buf_write_o, 1'b0);
      check("t5_packet", buf_packet_o, 0);
      exp_rd.delete();
      exp_wr.delete();
      pend_start = 1'b0;
      n_writes = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("t5_idle_after", busy_o, 1'b0);
      @(posedge clk_i); #2;

      // Randomized traffic: random latency, backpressure, misses and stops
      lat_fixed = -1;
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [LINE_ADDR_WIDTH-1:0] a;
         r = int'($urandom_range(0, 99));
         a = ($urandom_range(0, 3) == 0) ? 28'hFFFFFFC + LINE_ADDR_WIDTH'($urandom_range(0, 3))
                                         : LINE_ADDR_WIDTH'($urandom);
         step(r < 4 || r == 6, a, r >= 4 && r <= 6, $urandom_range(0, 99) < 30);
      end
      wait_idle(400);

      check("flush_count", seen_flush, exp_flush);
      check("pend_left", pend_start, 1'b0);
`ifdef STREAM_PF_STATS_EN
      check("stats_lines", pf_lines_o, n_writes);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
